// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one operand bit per clock); result registered and held between conversions.
// Optional macro BIN2BCD_SAT_EN: clamp the BCD output to all nines on overflow instead of wrapping mod 10^DIGITS.
module bin2bcd_seq #(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [DIGITS*4-1:0]   bcd,
    output logic                  ovf
);

    localparam int AW = DIGITS*4 + 1;
    localparam int CW = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t               st;
    logic [BIN_W-1:0]     bin_sr;
    logic [AW-1:0]        acc;
    logic [CW-1:0]        cnt;

    logic [AW-1:0]        acc_adj;
    logic                 ovf_nxt;
    logic [DIGITS*4-1:0]  bcd_nxt;

    // Add-3 on each digit nibble; the carry bit above the digits is left untouched.
    always_comb begin
        acc_adj = acc;
        for (int k = 0; k < DIGITS; k++) begin
            if (acc[4*k +: 4] >= 4'd5)
                acc_adj[4*k +: 4] = acc[4*k +: 4] + 4'd3;
        end
    end

    always_comb begin
        ovf_nxt = acc[AW-1];
        for (int k = 0; k < DIGITS; k++) begin
            if (acc[4*k +: 4] > 4'd9)
                ovf_nxt = 1'b1;
        end
`ifdef BIN2BCD_SAT_EN
        bcd_nxt = ovf_nxt ? {DIGITS{4'h9}} : acc[DIGITS*4-1:0];
`else
        bcd_nxt = acc[DIGITS*4-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st     <= IDLE;
            bin_sr <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            bcd    <= '0;
            ovf    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (st)
                IDLE: begin
                    if (start) begin
                        bin_sr <= bin;
                        acc    <= '0;
                        cnt    <= CW'(BIN_W);
                        busy   <= 1'b1;
                        st     <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc    <= {acc_adj[AW-2:0], bin_sr[BIN_W-1]};
                    bin_sr <= {bin_sr[BIN_W-2:0], 1'b0};
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        st <= LOAD;
                end
                LOAD: begin
                    bcd  <= bcd_nxt;
                    ovf  <= ovf_nxt;
                    done <= 1'b1;
                    busy <= 1'b0;
                    st   <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq at default parameters.
module tb_bin2bcd_seq;

    localparam int BIN_W  = 20;
    localparam int DIGITS = 6;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic [BIN_W-1:0]     bin;
    logic                 busy;
    logic                 done;
    logic [DIGITS*4-1:0]  bcd;
    logic                 ovf;

    int total_cnt;
    int pass_cnt;

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One conversion: strobe start for one edge, measure start-to-done latency, check result.
    task automatic convert(input string tag, input logic [31:0] val,
                           input logic [31:0] exp_bcd, input logic exp_ovf);
        int n;
        bin   = val[BIN_W-1:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy_hi"}, {31'd0, busy}, 32'd1);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done) begin
                n = i;
                break;
            end
        end
        chk({tag, "_latency"}, n, 32'd21);
        chk({tag, "_busy_lo"}, {31'd0, busy}, 32'd0);
        chk({tag, "_bcd"}, {8'd0, bcd}, exp_bcd);
        chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
        tick();
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_bcd_hold"}, {8'd0, bcd}, exp_bcd);
    endtask

    initial begin
        int dcnt;
        int dat;
        total_cnt = 0;
        pass_cnt  = 0;
        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        tick();
        tick();
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_bcd",  {8'd0, bcd},   32'd0);
        chk("rst_ovf",  {31'd0, ovf},  32'd0);
        rst = 1'b0;
        tick();

        convert("zero",   32'd0,       32'h000000, 1'b0);
        convert("c123456", 32'd123456, 32'h123456, 1'b0);
        convert("c999999", 32'd999999, 32'h999999, 1'b0);
`ifdef BIN2BCD_SAT_EN
        convert("c1048575", 32'd1048575, 32'h999999, 1'b1);
`else
        convert("c1048575", 32'd1048575, 32'h048575, 1'b1);
`endif

        // start held high for the whole conversion: exactly one done pulse
        bin   = 20'd42;
        start = 1'b1;
        tick();
        dcnt = 0;
        dat  = 0;
        for (int i = 1; i <= 21; i++) begin
            tick();
            if (done) begin
                dcnt++;
                dat = i;
            end
        end
        chk("held_done_count", dcnt, 32'd1);
        chk("held_done_at",    dat,  32'd21);
        chk("held_bcd", {8'd0, bcd}, 32'h000042);
        chk("held_ovf", {31'd0, ovf}, 32'd0);

        // re-strobe in the done cycle
        bin = 20'd7;
        tick();
        start = 1'b0;
        chk("restrobe_busy", {31'd0, busy}, 32'd1);
        dat = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done) begin
                dat = i;
                break;
            end
        end
        chk("restrobe_latency", dat, 32'd21);
        chk("restrobe_bcd", {8'd0, bcd}, 32'h000007);
        tick();

        // reset at the 10th SHIFT edge aborts the conversion
        bin   = 20'd500000;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 9; i++) tick();
        chk("abort_busy_pre", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_bcd",  {8'd0, bcd},   32'd0);
        chk("abort_ovf",  {31'd0, ovf},  32'd0);
        dcnt = 0;
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (done) dcnt++;
        end
        chk("abort_no_done", dcnt, 32'd0);

        convert("c314159", 32'd314159, 32'h314159, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
